// File: rtl/a2bus_arb_pkg.sv
// Shared types and helpers for the Apple II bus output arbiters.
// Holds the arbiter state encoding, the phase counter width and a popcount helper.
package a2bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TURN_ON,
    DRIVE,
    HOLD,
    TURN_OFF
  } arb_state_t;

  // Wide enough for the longest phase (MAX_DRIVE up to 63).
  localparam int CNT_W = 6;

  function automatic int unsigned popcount(input logic [7:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/a2bus_rr_picker.sv
// Combinational requester picker: fixed lowest-index priority, or rotating
// priority that starts at the entry after the last winner (ptr).
module a2bus_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               rr_mode,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = rr_mode ? int'(ptr) + 1 + i : i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/apple_bus_out_arbiter.sv
// Shares the card's data-bus output driver among NUM_REQ emulated devices and
// sequences transceiver DIR/OE around each Phi0 read window.
module apple_bus_out_arbiter
  import a2bus_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ROUND_ROBIN = 0,
  parameter int DRIVE_DELAY = 2,
  parameter int HOLD_COUNT  = 3,
  parameter int MAX_DRIVE   = 40
) (
  input  logic                 clk_logic_i,
  input  logic                 system_reset_n_i,
  input  logic                 timing_lock_i,
  input  logic                 phi0_posedge_i,
  input  logic                 phi0_negedge_i,
  input  logic                 rw_n_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic [7:0]           data_o,
  output logic                 data_dir_o,
  output logic                 data_oe_n_o,
  output logic                 conflict_o,
  output logic [7:0]           conflict_count_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   grant_idx_reg;
  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic [7:0]         req_bytes [NUM_REQ];
  logic [7:0]         sel_data;
  logic               rr_mode;
  logic               is_conflict;
  logic               start_read;
  logic               abort;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_bytes
    assign req_bytes[gi] = req_data_i[8*gi +: 8];
  end

  assign sel_data    = req_bytes[grant_idx_reg];
  assign rr_mode     = (ROUND_ROBIN != 0);
  assign is_conflict = popcount(8'(req_i)) > 1;
  assign start_read  = phi0_posedge_i && timing_lock_i && rw_n_i && (|req_i);
  // A new Phi0 start or loss of timing lock ends any cycle in progress.
  assign abort       = phi0_posedge_i || !timing_lock_i;

  a2bus_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req_i),
    .ptr     (ptr_reg),
    .rr_mode (rr_mode),
    .grant   (pick_grant),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
    if (!system_reset_n_i) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      ptr_reg          <= '0;
      grant_idx_reg    <= '0;
      grant_o          <= '0;
      data_o           <= '0;
      data_dir_o       <= 1'b0;
      data_oe_n_o      <= 1'b1;
      conflict_o       <= 1'b0;
      conflict_count_o <= '0;
    end else begin
      conflict_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_read) begin
            grant_o       <= pick_grant;
            grant_idx_reg <= pick_idx;
            ptr_reg       <= pick_idx;
            data_dir_o    <= 1'b1;
            cnt_reg       <= '0;
            conflict_o    <= is_conflict;
            if (is_conflict && conflict_count_o != 8'hFF)
              conflict_count_o <= conflict_count_o + 8'd1;
            state_reg     <= TURN_ON;
          end
        end
        TURN_ON: begin
          // Preload the byte so it is already valid when OE asserts.
          data_o <= sel_data;
          if (abort) begin
            data_oe_n_o <= 1'b1;
            state_reg   <= TURN_OFF;
          end else if (phi0_negedge_i) begin
            data_oe_n_o <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= HOLD;
          end else if (cnt_reg == CNT_W'(DRIVE_DELAY - 2)) begin
            data_oe_n_o <= 1'b0;
            cnt_reg     <= '0;
            state_reg   <= DRIVE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DRIVE: begin
          if (abort) begin
            data_oe_n_o <= 1'b1;
            state_reg   <= TURN_OFF;
          end else if (phi0_negedge_i || cnt_reg == CNT_W'(MAX_DRIVE - 1)) begin
            cnt_reg   <= '0;
            state_reg <= HOLD;
          end else begin
            data_o  <= sel_data;
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        HOLD: begin
          if (abort || cnt_reg == CNT_W'(HOLD_COUNT - 1)) begin
            data_oe_n_o <= 1'b1;
            state_reg   <= TURN_OFF;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        TURN_OFF: begin
          data_dir_o <= 1'b0;
          grant_o    <= '0;
          state_reg  <= IDLE;
        end
        default: begin
          data_oe_n_o <= 1'b1;
          state_reg   <= TURN_OFF;
        end
      endcase
    end
  end

endmodule
